mx_e2m3_to_fp32: RTL and testbench
==================================

# mx_e2m3_to_fp32

Decode stage for the FP32 ↔ MX-E2M3 path: accepts one MX block and streams back 32 FP32 values, one per cycle. A block is an E8M0 shared scale plus 32 packed E2M3 elements. It is the inverse of the FP32→MX shared-exponent/quantise path and sits at the consumer side of the MX storage or link. Conversion is exact, with no rounding. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- NELEM, 32, elements per block (fixed; the counter width is derived from it)
- EW, 6, element width (E2M3: sign, 2-bit exp, 3-bit mantissa)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  block offered
- in_ready  out  1  block accepted when in_valid & in_ready
- X_i  in  [8:1]  E8M0 shared scale; 8'hFF = NaN
- V_i  in  [192:1]  elements; element i = V_i[6i+6:6i+1]; bit 6 sign, [5:4] exp, [3:1] mantissa
- out_valid  out  1  FP32 element valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- Y  out  [32:1]  FP32 result
- idx  out  [5:1]  element index of Y (0..31)
- out_last  out  1  high with idx==31

## Operation
- States: IDLE (in_ready=1, out_valid=0) and EMIT (out_valid=1).
- IDLE: on in_fire, latch X_i and V_i, set idx=0, and go to EMIT.
- EMIT: on out_fire with idx<31, increment idx. On out_fire with idx==31: if in_valid, latch the new block, set idx=0, and stay in EMIT; otherwise go to IDLE.
- in_ready = IDLE | (out_valid & out_ready & out_last). This is the only path to back-to-back blocks.
- Y is a combinational decode of the latched scale and element[idx]. It is stable while out_valid & !out_ready.
- Decode of element (s,e,m) with scale X:
  - X==8'hFF → 32'h7FC00000 for every element, regardless of the element value.
  - e≠0, normal: biased exponent E = X + e − 1 (10-bit signed arithmetic); significand 1.m.
  - e==0, m≠0: p = position of the leading one in m (0..2); E = X + p − 3; significand is m normalised.
  - e==0, m==0 → {s, 31'b0} (signed zero).
  - E ≥ 255 → {s, 8'hFF, 23'b0} (infinity).
  - 1 ≤ E ≤ 254 → {s, E[8:1], frac}, where frac is the mantissa bits below the leading one, left-aligned in 23 bits.
  - E ≤ 0 → FP32 subnormal: {s, 8'h00, ({1,frac} aligned) >> (1−E)}. This is always exact, since the minimum magnitude is 2^-130.
- Reset clears: state=IDLE, latched scale=0, elements=0, idx=0. As a result out_valid=0, out_last=0, Y=32'h00000000, in_ready=1.

## Timing
- Latency: in_fire at cycle t → element 0 on Y with out_valid at t+1.
- Throughput: 1 element/cycle. Each block takes 32 cycles with no bubble between blocks when in_valid is held.
- Backpressure: out_ready=0 holds idx, Y, and out_last unchanged. in_ready stays 0 during EMIT except in the last-element fire cycle.
- rst asserted mid-block: the block is discarded. Next cycle out_valid=0 and in_ready=1. An in_valid present in the rst cycle is ignored.
- in_valid while in EMIT and not at the last fire: not accepted; the producer must hold it.

## Structure
- Shared package mx_pkg holds: FP32_BIAS=127, E2M3_BIAS=1, E8M0_NAN=8'hFF, FP32_QNAN=32'h7FC00000, MX_NELEM=32, E2M3_W=6.
- One combinational sub-module, e2m3_scale_to_fp32 (X[8:1], elem[6:1] → Y[32:1]). It is also reusable for a parallel-decode variant. The top contains the FSM, the block register, the counter, and the element mux.

## Test plan
- X=127, element0=0_01_000, element1=0_10_100, element2=1_00_100 → Y=3F800000, 40400000, BF000000 at idx 0,1,2, first at cycle t+1.
- X=8'hFF with a mixed-value block → all 32 outputs are 7FC00000; out_last only with idx=31.
- X=254, elements 0_11_111 and 1_10_000 → 7F800000 and FF800000. Elements 0_00_000 and 1_00_000 → 00000000 and 80000000.
- X=0, elements 0_00_001 and 0_01_000 → 00080000 and 00400000 (subnormal outputs, exact).
- Two blocks with in_valid held: 64 outputs in 64 consecutive cycles. in_ready pulses only on the idx=31 fire. out_ready low for 3 cycles at idx=5 → Y and idx held, and no element is lost.
- rst during EMIT at idx=10 → next cycle out_valid=0, in_ready=1, Y=0. A fresh block afterwards restarts at idx=0.

Source files
------------

// File: rtl/mx_pkg.sv
// Shared constants and types for the MX (E8M0 scale + E2M3 element) decode path.
package mx_pkg;

  localparam int unsigned FP32_BIAS = 127;
  localparam int unsigned E2M3_BIAS = 1;
  localparam logic [7:0]  E8M0_NAN  = 8'hFF;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam int unsigned MX_NELEM  = 32;
  localparam int unsigned E2M3_W    = 6;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } mx_state_e;

endpackage

// File: rtl/e2m3_scale_to_fp32.sv
// Exact combinational decode of one E2M3 element under an E8M0 shared scale into FP32.
module e2m3_scale_to_fp32
  import mx_pkg::*;
(
  input  logic [8:1]  X,
  input  logic [6:1]  elem,
  output logic [32:1] Y
);

  logic               w_sign;
  logic [1:0]         w_e;
  logic [2:0]         w_m;
  logic [2:0]         w_frac;
  logic signed [9:0]  w_exp;
  logic [9:0]         w_shamt;
  logic [23:0]        w_sig;

  always_comb begin
    w_sign  = elem[6];
    w_e     = elem[5:4];
    w_m     = elem[3:1];
    w_frac  = '0;
    w_exp   = '0;
    w_shamt = '0;
    w_sig   = '0;
    Y       = '0;

    // Element subnormals are m/8: renormalise so frac holds the bits below the leading one.
    if (w_e != 2'b00) begin
      w_exp  = 10'(X) + 10'(w_e) - 10'(E2M3_BIAS);
      w_frac = w_m;
    end else if (w_m[2]) begin
      w_exp  = 10'(X) - 10'd1;
      w_frac = {w_m[1:0], 1'b0};
    end else if (w_m[1]) begin
      w_exp  = 10'(X) - 10'd2;
      w_frac = {w_m[0], 2'b00};
    end else begin
      w_exp  = 10'(X) - 10'd3;
      w_frac = '0;
    end

    w_sig   = {1'b1, w_frac, 20'b0};
    w_shamt = 10'd1 - w_exp;

    if (X == E8M0_NAN) begin
      Y = FP32_QNAN;
    end else if (w_e == 2'b00 && w_m == 3'b000) begin
      Y = {w_sign, 31'b0};
    end else if (w_exp >= 10'sd255) begin
      Y = {w_sign, 8'hFF, 23'b0};
    end else if (w_exp >= 10'sd1) begin
      Y = {w_sign, w_exp[7:0], w_frac, 20'b0};
    end else begin
      // Shift is at most 4 and frac occupies only the top 3 bits, so nothing is lost.
      Y = {w_sign, 8'h00, 23'(w_sig >> w_shamt)};
    end
  end

endmodule

// File: rtl/mx_e2m3_to_fp32.sv
// MX block decoder: latches one scale + NELEM E2M3 elements and streams FP32 values one per cycle.
module mx_e2m3_to_fp32
  import mx_pkg::*;
#(
  parameter int unsigned NELEM = MX_NELEM,
  parameter int unsigned EW    = E2M3_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8:1]                X_i,
  input  logic [NELEM*EW:1]         V_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32:1]               Y,
  output logic [$clog2(NELEM):1]    idx,
  output logic                      out_last
);

  localparam int unsigned IW   = $clog2(NELEM);
  localparam logic [IW:1] LAST = IW'(NELEM - 1);

  mx_state_e          r_state;
  mx_state_e          w_state_nxt;
  logic [8:1]         r_scale;
  logic [NELEM*EW:1]  r_elems;
  logic [IW:1]        r_idx;
  logic               w_at_last;
  logic               w_load;
  logic               w_adv;
  logic [EW:1]        w_elem;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_at_last   = (r_idx == LAST);

    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (w_at_last) begin
            // Last-element fire doubles as the acceptance slot for the next block.
            in_ready = 1'b1;
            if (in_valid) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scale <= '0;
      r_elems <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_scale <= X_i;
      r_elems <= V_i;
      r_idx   <= '0;
    end else if (w_adv) begin
      r_idx   <= r_idx + IW'(1);
    end
  end

  assign w_elem   = r_elems[EW*r_idx+1 +: EW];
  assign idx      = r_idx;
  assign out_last = (r_state == ST_EMIT) && w_at_last;

  e2m3_scale_to_fp32 u_dec (
    .X    (r_scale),
    .elem (w_elem),
    .Y    (Y)
  );

endmodule

// File: tb/tb_mx_e2m3_to_fp32.sv
// Bench for mx_e2m3_to_fp32: directed cases plus random blocks against a value-level FP32 model.
module tb_mx_e2m3_to_fp32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [8:1]   X_i;
  logic [192:1] V_i;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [32:1]  Y;
  logic [5:1]   idx;
  logic         out_last;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_item;
  bit   prev_fire = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;

  always #5 clk = ~clk;

  mx_e2m3_to_fp32 #(
    .NELEM (32),
    .EW    (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X_i       (X_i),
    .V_i       (V_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .idx       (idx),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, expv);
    end
  endtask

  // Element magnitude is k/8 with k an integer, so value = k * 2^(x-130); encode that into FP32.
  function automatic logic [31:0] model(input logic [7:0] x, input logic [5:0] el);
    int k, q, eb, e, m;
    logic s;
    s = el[5];
    e = int'(el[4:3]);
    m = int'(el[2:0]);
    if (x == 8'hFF) return 32'h7FC00000;
    k = (e == 0) ? m : ((8 + m) << (e - 1));
    if (k == 0) return {s, 31'b0};
    q = 0;
    for (int b = 0; b < 6; b++) if ((k >> b) & 1) q = b;
    eb = int'(x) + q - 3;
    if (eb >= 255) return {s, 8'hFF, 23'b0};
    if (eb >= 1) return {s, 8'(eb), 23'((k << (23 - q)) & 32'h007FFFFF)};
    return {s, 8'h00, 23'(k << (int'(x) + 19))};
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_force;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_fire = 1'b0;
    end else begin
      if (prev_fire) check("latency_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(exp_q.size()), 32'd1);
        end else begin
          check("Y", Y, exp_q[0].y);
          check("idx", 32'(idx), 32'(exp_q[0].idx));
          check("last", 32'(out_last), 32'(exp_q[0].idx == 5'd31));
          check("in_ready_emit", 32'(in_ready), 32'(out_ready && exp_q[0].idx == 5'd31));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("in_ready_idle", 32'(in_ready), 32'd1);
      end
      prev_fire = in_valid && in_ready;
      if (prev_fire) begin
        for (int i = 0; i < 32; i++) begin
          exp_item.y   = model(X_i, V_i[6*i+1 +: 6]);
          exp_item.idx = 5'(i);
          exp_q.push_back(exp_item);
        end
      end
    end
  end

  task automatic send_block(input logic [7:0] x, input logic [191:0] v);
    X_i = x;
    V_i = v;
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!out_valid) return;
    end
    check("drain_timeout", 32'(out_valid), 32'd0);
  endtask

  task automatic expect_next(input string tag, input logic [31:0] ev);
    @(negedge clk);
    check(tag, Y, ev);
  endtask

  function automatic logic [191:0] rand_block();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] v, vb;
    logic [7:0]   x;
    int           valid_cnt, accepts, k, r;
    bit           got_fire;

    rst = 1'b1;
    in_valid = 1'b0;
    X_i = '0;
    V_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_Y", Y, 32'h0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);

    v = rand_block();
    v[0 +: 6]  = 6'b0_01_000;
    v[6 +: 6]  = 6'b0_10_100;
    v[12 +: 6] = 6'b1_00_100;
    send_block(8'd127, v);
    expect_next("t1_e0", 32'h3F800000);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_idx0", 32'(idx), 32'd0);
    expect_next("t1_e1", 32'h40400000);
    expect_next("t1_e2", 32'hBF000000);
    wait_idle();

    send_block(8'hFF, rand_block());
    for (int i = 0; i < 32; i++) begin
      expect_next("nan_Y", 32'h7FC00000);
      check("nan_last", 32'(out_last), 32'(i == 31));
    end
    wait_idle();

    v = rand_block();
    v[0 +: 6]  = 6'b0_11_111;
    v[6 +: 6]  = 6'b1_10_000;
    v[12 +: 6] = 6'b0_00_000;
    v[18 +: 6] = 6'b1_00_000;
    send_block(8'd254, v);
    expect_next("inf_pos", 32'h7F800000);
    expect_next("inf_neg", 32'hFF800000);
    expect_next("zero_pos", 32'h00000000);
    expect_next("zero_neg", 32'h80000000);
    wait_idle();

    v = rand_block();
    v[0 +: 6] = 6'b0_00_001;
    v[6 +: 6] = 6'b0_01_000;
    send_block(8'd0, v);
    expect_next("sub_min", 32'h00080000);
    expect_next("sub_e1", 32'h00400000);
    wait_idle();

    // Two blocks back to back with a 3-cycle stall at idx 5.
    v  = rand_block();
    vb = rand_block();
    send_block(8'($urandom_range(100, 150)), v);
    X_i = 8'($urandom_range(100, 150));
    V_i = vb;
    in_valid = 1'b1;
    valid_cnt = 0;
    accepts = 0;
    for (int c = 0; c < 67; c++) begin
      @(negedge clk);
      if (out_valid) valid_cnt++;
      k = (c <= 5) ? c : ((c <= 8) ? 5 : c - 3);
      check("b2b_idx", 32'(idx), 32'(k % 32));
      got_fire = in_valid && in_ready;
      if (got_fire) accepts++;
      @(posedge clk);
      ready_force = !((c + 1) >= 5 && (c + 1) <= 7);
      #1;
      if (got_fire) in_valid = 1'b0;
    end
    check("b2b_valid_cycles", 32'(valid_cnt), 32'd67);
    check("b2b_accepts", 32'(accepts), 32'd1);
    @(negedge clk);
    check("b2b_end_idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a block, with a competing block offered.
    send_block(8'd127, rand_block());
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid && idx == 5'd10) break;
    end
    check("pre_rst_idx", 32'(idx), 32'd10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    X_i = 8'd130;
    V_i = rand_block();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_Y", Y, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_ignores_in", 32'(out_valid), 32'd0);
    send_block(8'd127, rand_block());
    @(negedge clk);
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_idx", 32'(idx), 32'd0);
    wait_idle();

    rand_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      x = 8'hFF;
      else if (r == 1) x = 8'($urandom_range(0, 4));
      else if (r == 2) x = 8'($urandom_range(250, 254));
      else             x = 8'($urandom_range(100, 160));
      send_block(x, rand_block());
    end
    rand_ready = 1'b0;
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
